// File: rtl/any1_vstep_if.sv
// any1_vstep interface: issue-side control plus memory valid/ack.
// master drives start/vl/mask/flush/ack; slave is the sequencer.
interface any1_vstep_if #(
  parameter int VLMAX = 64
);
  localparam int SW = $clog2(VLMAX);

  logic             start;
  logic [SW:0]      vl;
  logic [VLMAX-1:0] mask;
  logic             flush;
  logic             ack;
  logic [SW-1:0]    step;
  logic             req;
  logic             busy;
  logic             done;
  logic [SW:0]      elem_cnt;

  modport master (
    output start, vl, mask, flush, ack,
    input  step, req, busy, done, elem_cnt
  );

  modport slave (
    input  start, vl, mask, flush, ack,
    output step, req, busy, done, elem_cnt
  );
endinterface

// File: rtl/any1_vstep.sv
// any1_vstep: vector element sequencer feeding the agen step input.
// Define ANY1_VSTEP_MASK_EN to honor the element mask.
module any1_vstep #(
  parameter int VLMAX = 64
) (
  input logic         clk,
  input logic         rst,
  any1_vstep_if.slave v
);
  localparam int SW = $clog2(VLMAX);
  localparam int LW = SW + 1;

  typedef enum logic [1:0] {
    IDLE, AGEN, REQ, DONE
  } st_t;

  st_t           st, nst;
  logic [SW-1:0] step_q;
  logic [SW-1:0] nidx;
  logic [LW-1:0] vl_q;
  logic [LW-1:0] vlc;
  logic [LW-1:0] lim;
  logic [LW-1:0] base;
  logic [LW-1:0] cnt;
  logic          found;
  logic          go;
  logic          adv;

  assign vlc = (v.vl > LW'(VLMAX))
             ? LW'(VLMAX) : v.vl;
  assign lim = (st == IDLE) ? vlc : vl_q;
  // Search is done at LW bits so step=max cannot wrap to 0
  assign base = (st == IDLE) ? '0
              : {1'b0, step_q} + LW'(1);

  assign go  = (st == IDLE) && v.start;
  assign adv = (st == REQ) && v.ack && !v.flush;

`ifdef ANY1_VSTEP_MASK_EN
  logic [VLMAX-1:0] mask_q;
  logic [VLMAX-1:0] msk;
  logic [VLMAX-1:0] cand;

  assign msk = (st == IDLE) ? v.mask : mask_q;

  always_comb begin
    cand  = '0;
    nidx  = '0;
    found = 1'b0;
    for (int i = 0; i < VLMAX; i++)
      cand[i] = msk[i]
             && (LW'(i) >= base)
             && (LW'(i) < lim);
    for (int i = VLMAX - 1; i >= 0; i--)
      if (cand[i]) begin
        nidx  = SW'(i);
        found = 1'b1;
      end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst)
      mask_q <= '0;
    else if (go)
      mask_q <= v.mask;
`else
  logic unused_mask;

  assign unused_mask = ^v.mask;
  assign nidx        = base[SW-1:0];
  assign found       = base < lim;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst)
      st <= IDLE;
    else
      st <= nst;

  always_comb begin
    nst = st;
    unique case (st)
      IDLE: if (v.start)
              nst = found ? AGEN : DONE;
      AGEN: nst = REQ;
      REQ:  if (v.ack)
              nst = found ? AGEN : DONE;
      DONE: nst = IDLE;
      default: nst = IDLE;
    endcase
    if (v.flush && st != IDLE)
      nst = IDLE;
  end

  always_comb begin
    v.req      = (st == REQ);
    v.busy     = (st != IDLE);
    v.done     = (st == DONE);
    v.step     = step_q;
    v.elem_cnt = cnt;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      step_q <= '0;
      vl_q   <= '0;
      cnt    <= '0;
    end else if (go) begin
      vl_q <= vlc;
      cnt  <= '0;
      if (found)
        step_q <= nidx;
    end else if (adv) begin
      cnt <= cnt + LW'(1);
      if (found)
        step_q <= nidx;
    end
endmodule

// File: tb/tb_any1_vstep.sv
// any1_vstep bench: directed steps, scoreboard of expected steps.
// Expectations follow ANY1_VSTEP_MASK_EN when it is defined.
module tb_any1_vstep;
`ifdef ANY1_VSTEP_MASK_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errs = 0;
  int   checks = 0;
  logic [5:0] exp_q[$];

  any1_vstep_if v ();

  any1_vstep dut (
    .clk (clk),
    .rst (rst),
    .v   (v)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic op(
    input string       tag,
    input logic [6:0]  vlv,
    input logic [63:0] m,
    input int          w
  );
    int n, cyc, hold, dcyc, reqn, lim;
    logic [5:0] e;
    lim = (vlv > 7'd64) ? 64 : int'(vlv);
    exp_q.delete();
    for (int i = 0; i < lim; i++)
      if (!MEN || m[i])
        exp_q.push_back(6'(i));
    n    = exp_q.size();
    cyc  = 0;
    hold = 0;
    dcyc = -1;
    reqn = 0;
    v.start = 1'b1;
    v.vl    = vlv;
    v.mask  = m;
    v.ack   = 1'b0;
    while (dcyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      v.start = 1'b0;
      v.ack   = 1'b0;
      if (v.done)
        dcyc = cyc;
      if (v.req) begin
        if (hold >= w) begin
          v.ack = 1'b1;
          hold  = 0;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ".step"},
                64'(v.step), 64'(e));
          end
          if (w == 0)
            chk({tag, ".reqcyc"},
                64'(cyc), 64'(2 + 2 * reqn));
          reqn++;
        end else begin
          hold++;
        end
      end
    end
    if (w == 0)
      chk({tag, ".donecyc"}, 64'(dcyc),
          64'((n == 0) ? 1 : 2 * n + 1));
    else
      chk({tag, ".done"}, 64'(dcyc > 0), 64'(1));
    chk({tag, ".reqs"}, 64'(reqn), 64'(n));
    chk({tag, ".cnt"}, 64'(v.elem_cnt), 64'(n));
    @(negedge clk);
    chk({tag, ".idle"}, 64'(v.busy), 64'(0));
    chk({tag, ".d1"}, 64'(v.done), 64'(0));
  endtask

  initial begin
    int   cyc, reqn;
    logic fl;
    v.start = 1'b0;
    v.vl    = '0;
    v.mask  = '0;
    v.flush = 1'b0;
    v.ack   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.step", 64'(v.step), 64'(0));
    chk("rst.req",  64'(v.req),  64'(0));
    chk("rst.busy", 64'(v.busy), 64'(0));
    chk("rst.done", 64'(v.done), 64'(0));
    chk("rst.cnt",  64'(v.elem_cnt), 64'(0));
    rst = 1'b1;

    op("vl4",   7'd4,   '1,        0);
    op("m91",   7'd8,   64'h91,    0);
    op("vl0",   7'd0,   '1,        0);
    op("m20",   7'd5,   64'h20,    0);
    op("b63",   7'd64,  64'h1<<63, 0);
    op("clamp", 7'd100, '1,        0);
    op("slow",  7'd5,   64'h15,    2);

    // flush with ack on third element, start mid-op
    v.vl    = 7'd6;
    v.mask  = '1;
    v.start = 1'b1;
    cyc  = 0;
    reqn = 0;
    fl   = 1'b0;
    while (!fl && cyc < 100) begin
      @(negedge clk);
      cyc++;
      v.start = (cyc == 3);
      v.vl    = (cyc == 3) ? 7'd2 : 7'd6;
      v.ack   = 1'b0;
      if (v.req) begin
        chk("fl.step", 64'(v.step), 64'(reqn));
        v.ack = 1'b1;
        if (reqn == 2) begin
          v.flush = 1'b1;
          fl = 1'b1;
        end
        reqn++;
      end
    end
    chk("fl.seen", 64'(fl), 64'(1));
    @(negedge clk);
    v.ack   = 1'b0;
    v.flush = 1'b0;
    chk("fl.busy", 64'(v.busy), 64'(0));
    chk("fl.req",  64'(v.req),  64'(0));
    chk("fl.done", 64'(v.done), 64'(0));
    chk("fl.cnt",  64'(v.elem_cnt), 64'(2));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("fl.nodone", 64'(v.done), 64'(0));
    end

    // start and flush together in IDLE
    v.vl    = 7'd1;
    v.start = 1'b1;
    v.flush = 1'b1;
    @(negedge clk);
    v.start = 1'b0;
    v.flush = 1'b0;
    chk("sf.busy", 64'(v.busy), 64'(1));
    chk("sf.step", 64'(v.step), 64'(0));
    @(negedge clk);
    chk("sf.req", 64'(v.req), 64'(1));
    v.ack = 1'b1;
    @(negedge clk);
    v.ack = 1'b0;
    chk("sf.done", 64'(v.done), 64'(1));
    chk("sf.cnt",  64'(v.elem_cnt), 64'(1));
    @(negedge clk);
    chk("sf.idle", 64'(v.busy), 64'(0));

    // async reset while in REQ for element 1
    v.vl    = 7'd4;
    v.start = 1'b1;
    @(negedge clk);
    v.start = 1'b0;
    @(negedge clk);
    v.ack = 1'b1;
    @(negedge clk);
    v.ack = 1'b0;
    @(negedge clk);
    chk("ar.req1",  64'(v.req),  64'(1));
    chk("ar.step1", 64'(v.step), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("ar.req",  64'(v.req),  64'(0));
    chk("ar.busy", 64'(v.busy), 64'(0));
    chk("ar.step", 64'(v.step), 64'(0));
    chk("ar.cnt",  64'(v.elem_cnt), 64'(0));
    @(negedge clk);
    chk("ar.nodone", 64'(v.done), 64'(0));
    rst = 1'b1;
    op("post", 7'd3, '1, 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
